uart_num_asc: RTL and testbench

//  Transmit-side counterpart of the UART hex-ASCII receiver/decoder. Captures three 32-bit

---
 rtl/uart_asc_pkg.sv | 18 +
 rtl/hex_nibble_asc.sv | 18 +
 rtl/uart_num_asc.sv | 118 +++++++++++
 tb/tb_uart_num_asc.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_asc_pkg.sv
// Shared constants and FSM encoding for the UART hex-ASCII transmit/receive pair.
// Both the transmit serialiser and the receive-side decoder import this package.
package uart_asc_pkg;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_UA = 8'h41;
  localparam logic [7:0] ASC_LA = 8'h61;
  localparam logic [7:0] ASC_LF = 8'h0A;

  localparam int NCHAR = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } asc_state_t;

endpackage

// File: rtl/hex_nibble_asc.sv
// Converts one 4-bit nibble to its hex ASCII character, with selectable letter case.
module hex_nibble_asc
  import uart_asc_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       upper,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASC_0 + {4'h0, nibble};
    end else begin
      ascii = (upper ? ASC_UA : ASC_LA) + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/uart_num_asc.sv
// Serialises three captured 32-bit words as 24 hex ASCII characters (x, y, z; MSB nibble
// first) over a valid/ready byte interface, optionally followed by a terminator character.
module uart_num_asc
  import uart_asc_pkg::*;
#(
  parameter bit         UPPERCASE = 1'b1,
  parameter bit         TERM_EN   = 1'b0,
  parameter logic [7:0] TERM_CHAR = ASC_LF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] xdatain,
  input  logic [31:0] ydatain,
  input  logic [31:0] zdatain,
  input  logic        start,
  input  logic        clr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX = TERM_EN ? 5'(NCHAR) : 5'(NCHAR - 1);

  asc_state_t  state;
  logic        start_d;
  logic        start_edge;
  logic        xfer;
  logic [95:0] shadow;
  logic [95:0] src;
  logic [4:0]  count;
  logic [4:0]  next_idx;
  logic [3:0]  nib;
  logic [7:0]  nib_asc;
  logic [7:0]  next_char;

  assign start_edge = start & ~start_d;
  assign xfer       = tx_valid & tx_ready;

  // The character for the next index is prepared ahead so tx_data can be registered;
  // in IDLE the source is the live inputs, since the shadow is being loaded the same cycle.
  always_comb begin
    src      = shadow;
    next_idx = count + 5'd1;
    if (state == IDLE) begin
      src      = {xdatain, ydatain, zdatain};
      next_idx = '0;
    end
    nib = '0;
    for (int k = 0; k < NCHAR; k++) begin
      if (next_idx == 5'(k)) begin
        nib = src[95 - 4*k -: 4];
      end
    end
    next_char = (TERM_EN && (next_idx == 5'(NCHAR))) ? TERM_CHAR : nib_asc;
  end

  hex_nibble_asc u_hex (
    .nibble (nib),
    .upper  (UPPERCASE),
    .ascii  (nib_asc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      start_d  <= 1'b0;
      shadow   <= '0;
      count    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      start_d <= start;
      done    <= 1'b0;
      // clr wins over everything, including a start edge in the same cycle.
      if (clr) begin
        state    <= IDLE;
        count    <= '0;
        tx_data  <= '0;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) begin
              shadow   <= src;
              count    <= '0;
              tx_data  <= next_char;
              tx_valid <= 1'b1;
              busy     <= 1'b1;
              state    <= SEND;
            end
          end
          SEND: begin
            if (xfer) begin
              if (count == LAST_IDX) begin
                count    <= '0;
                tx_valid <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= FIN;
              end else begin
                count   <= next_idx;
                tx_data <= next_char;
              end
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_num_asc.sv
// Scoreboard bench for uart_num_asc: two instances (upper-case/no terminator and
// lower-case/LF terminator) share stimulus; a string-formatting model predicts each byte.
module tb_uart_num_asc;

  localparam int DONE_TOKEN = 256;

  logic        clk;
  logic        rst;
  logic [31:0] xdatain;
  logic [31:0] ydatain;
  logic [31:0] zdatain;
  logic        start;
  logic        clr;
  logic        tx_ready;
  logic [7:0]  tx_data_a;
  logic        tx_valid_a;
  logic        busy_a;
  logic        done_a;
  logic [7:0]  tx_data_b;
  logic        tx_valid_b;
  logic        busy_b;
  logic        done_b;

  int checks = 0;
  int errors = 0;
  int exp_a[$];
  int exp_b[$];
  int xfer_cnt_a = 0;
  int xfer_cnt_b = 0;
  int ready_mode = 0;
  int cyc = 0;
  bit hold_a = 0;
  bit hold_b = 0;
  logic [7:0] hold_data_a = '0;
  logic [7:0] hold_data_b = '0;

  uart_num_asc #(
    .UPPERCASE (1'b1),
    .TERM_EN   (1'b0),
    .TERM_CHAR (8'h0A)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .xdatain  (xdatain),
    .ydatain  (ydatain),
    .zdatain  (zdatain),
    .start    (start),
    .clr      (clr),
    .tx_data  (tx_data_a),
    .tx_valid (tx_valid_a),
    .tx_ready (tx_ready),
    .busy     (busy_a),
    .done     (done_a)
  );

  uart_num_asc #(
    .UPPERCASE (1'b0),
    .TERM_EN   (1'b1),
    .TERM_CHAR (8'h0A)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .xdatain  (xdatain),
    .ydatain  (ydatain),
    .zdatain  (zdatain),
    .start    (start),
    .clr      (clr),
    .tx_data  (tx_data_b),
    .tx_valid (tx_valid_b),
    .tx_ready (tx_ready),
    .busy     (busy_b),
    .done     (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Modes: 0 always ready, 1 one cycle in three, 2 random, otherwise held low.
  always @(posedge clk) begin
    #2;
    cyc++;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ((cyc % 3) == 0);
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Reference model: the frame is simply the 24-digit hex rendering of {x,y,z}.
  task automatic pushFrame(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    string s;
    string su;
    s  = $sformatf("%08h%08h%08h", x, y, z);
    su = s.toupper();
    for (int i = 0; i < su.len(); i++) exp_a.push_back(int'(su[i]));
    exp_a.push_back(DONE_TOKEN);
    for (int i = 0; i < s.len(); i++) exp_b.push_back(int'(s[i]));
    exp_b.push_back(8'h0A);
    exp_b.push_back(DONE_TOKEN);
  endtask

  task automatic sbPop(input int which, output int exp, output bit ok);
    exp = -1;
    ok  = 1'b0;
    if (which == 0) begin
      if (exp_a.size() > 0) begin
        exp = exp_a.pop_front();
        ok  = 1'b1;
      end
    end else begin
      if (exp_b.size() > 0) begin
        exp = exp_b.pop_front();
        ok  = 1'b1;
      end
    end
  endtask

  task automatic observe(input int which, input logic [7:0] data, input logic valid,
                         input logic dn);
    int    exp;
    bit    ok;
    string tag;
    tag = (which == 0) ? "a" : "b";
    if ((which == 0) ? hold_a : hold_b) begin
      checkOutput({"stall_valid_", tag}, int'(valid), 1);
      checkOutput({"stall_data_", tag}, int'(data),
                  int'((which == 0) ? hold_data_a : hold_data_b));
    end
    if (valid && tx_ready) begin
      sbPop(which, exp, ok);
      if (!ok) checkOutput({"extra_char_", tag}, int'(data), -1);
      else     checkOutput({"char_", tag}, int'(data), exp);
      if (which == 0) xfer_cnt_a++;
      else            xfer_cnt_b++;
    end
    if (dn) begin
      sbPop(which, exp, ok);
      if (!ok) checkOutput({"extra_done_", tag}, int'(dn) << 8, -1);
      else     checkOutput({"done_", tag}, int'(dn) << 8, exp);
    end
    if (which == 0) begin
      hold_a      = valid && !tx_ready && !clr;
      hold_data_a = data;
    end else begin
      hold_b      = valid && !tx_ready && !clr;
      hold_data_b = data;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_a = 1'b0;
      hold_b = 1'b0;
    end else begin
      observe(0, tx_data_a, tx_valid_a, done_a);
      observe(1, tx_data_b, tx_valid_b, done_b);
    end
  end

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    @(posedge clk);
    #1;
    xdatain = x;
    ydatain = y;
    zdatain = z;
    start   = 1'b1;
    pushFrame(x, y, z);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) checkOutput("idle_timeout", exp_a.size() + exp_b.size(), 0);
  endtask

  task automatic waitXfers(input int target);
    int n;
    n = 0;
    while (xfer_cnt_a < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) checkOutput("xfer_timeout", xfer_cnt_a, target);
  endtask

  task automatic checkQuiet(input string name);
    checkOutput({name, "_valid_a"}, int'(tx_valid_a), 0);
    checkOutput({name, "_busy_a"}, int'(busy_a), 0);
    checkOutput({name, "_done_a"}, int'(done_a), 0);
    checkOutput({name, "_valid_b"}, int'(tx_valid_b), 0);
    checkOutput({name, "_busy_b"}, int'(busy_b), 0);
    checkOutput({name, "_done_b"}, int'(done_b), 0);
  endtask

  initial begin
    int lat_a;
    int lat_b;
    int base;
    rst        = 1'b0;
    start      = 1'b0;
    clr        = 1'b0;
    xdatain    = '0;
    ydatain    = '0;
    zdatain    = '0;
    tx_ready   = 1'b0;
    ready_mode = 0;
    #2 rst = 1'b1;
    #1;
    checkQuiet("reset");
    checkOutput("reset_data_a", int'(tx_data_a), 0);
    checkOutput("reset_data_b", int'(tx_data_b), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] directed frame, ready always high");
    applyStimulus(32'h12345678, 32'h9ABCDEF0, 32'h00000001);
    lat_a = 0;
    lat_b = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("first_valid_a", int'(tx_valid_a), 1);
      if (done_a && lat_a == 0) lat_a = k;
      if (done_b && lat_b == 0) lat_b = k;
    end
    checkOutput("done_latency_a", lat_a, 25);
    checkOutput("done_latency_b", lat_b, 26);
    waitIdle();

    $display("[TB] same frame, ready one cycle in three");
    ready_mode = 1;
    applyStimulus(32'h12345678, 32'h9ABCDEF0, 32'h00000001);
    waitIdle();

    $display("[TB] lower-case letters");
    ready_mode = 2;
    applyStimulus(32'hDEADBEEF, $urandom, $urandom);
    waitIdle();

    $display("[TB] start edge and input change mid-frame");
    ready_mode = 0;
    base = xfer_cnt_a;
    applyStimulus($urandom, $urandom, $urandom);
    waitXfers(base + 5);
    @(posedge clk);
    #1;
    xdatain = '0;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitIdle();

    $display("[TB] start edge during FIN");
    applyStimulus($urandom, $urandom, $urandom);
    repeat (24) @(posedge clk);
    #1 start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    waitIdle();
    repeat (4) @(negedge clk);
    checkQuiet("fin_edge");

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      ready_mode = $urandom_range(0, 2);
      applyStimulus($urandom, $urandom, $urandom);
      waitIdle();
    end

    $display("[TB] clr abort after ten characters");
    ready_mode = 2;
    base = xfer_cnt_a;
    applyStimulus($urandom, $urandom, $urandom);
    waitXfers(base + 10);
    ready_mode = 3;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("clr_pre_valid_a", int'(tx_valid_a), 1);
    clr = 1'b1;
    exp_a.delete();
    exp_b.delete();
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    checkQuiet("clr");
    ready_mode = 0;
    repeat (5) @(negedge clk);
    checkQuiet("clr_idle");
    applyStimulus($urandom, $urandom, $urandom);
    waitIdle();

    $display("[TB] asynchronous reset mid-frame");
    ready_mode = 2;
    applyStimulus($urandom, $urandom, $urandom);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    exp_a.delete();
    exp_b.delete();
    #1;
    checkQuiet("async_rst");
    checkOutput("async_rst_data_a", int'(tx_data_a), 0);
    checkOutput("async_rst_data_b", int'(tx_data_b), 0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkQuiet("post_rst");
    ready_mode = 0;
    applyStimulus($urandom, $urandom, $urandom);
    waitIdle();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
